sistema_pio_in: RTL and testbench
=================================

SISTEMA_PIO_IN -- requirements
Module: sistema_pio_in

Interface
REQ-001 The block SHALL have parameter WIDTH, default 14, giving the input port width (1..32).
REQ-002 The block SHALL have port clk, input, 1 bit: the single clock; all state SHALL be on its rising edge.
REQ-003 The block SHALL have port reset, input, 1 bit: reset, asynchronous and active-high.
REQ-004 The block SHALL have port address, input, 2 bits: register select.
REQ-005 The block SHALL have port chipselect, input, 1 bit: slave select.
REQ-006 The block SHALL have port read_n, input, 1 bit: active-low read strobe.
REQ-007 The block SHALL have port write_n, input, 1 bit: active-low write strobe.
REQ-008 The block SHALL have port writedata, input, 32 bits: write data.
REQ-009 The block SHALL have port in_port, input, WIDTH bits: asynchronous external inputs.
REQ-010 The block SHALL have port readdata, output, 32 bits: registered read data.
REQ-011 The block SHALL have port irq, output, 1 bit: level interrupt request.

Function
REQ-012 The block SHALL pass in_port through a two-flop synchronizer (s1, s2) and a third history flop (s3).
REQ-013 The block SHALL implement this register map:
- 0 = DATA (read-only, s2)
- 1 = reserved (reads 0)
- 2 = IRQMASK (RW, bits [WIDTH-1:0])
- 3 = EDGECAP (read, write-1-to-clear)
REQ-014 A write SHALL occur when chipselect=1 and write_n=0; bits above WIDTH-1 SHALL be ignored; writes to addresses 0 and 1 SHALL have no effect.
REQ-015 EDGECAP bit i SHALL set on the clock edge after s2[i]=1 and s3[i]=0 (rising edge only).
REQ-016 A write to EDGECAP SHALL clear each bit whose writedata bit is 1 and leave other bits unchanged.
REQ-017 If a set and a clear hit the same EDGECAP bit in the same cycle, the set SHALL win and the bit SHALL remain 1.
REQ-018 readdata SHALL be registered, with a read latency of one cycle: when chipselect=1 and read_n=0 at edge N, readdata after edge N SHALL hold the addressed register zero-extended to 32 bits.
REQ-019 readdata SHALL hold its value when no read is presented.
REQ-020 Reads SHALL have no side effects; a read and a write in the same cycle SHALL return the pre-write value.
REQ-021 The delay from an in_port change to that change being visible in DATA (s2) SHALL be 2 cycles.
REQ-022 The delay from an in_port rising edge to the corresponding EDGECAP bit being set SHALL be 3 cycles.
REQ-023 irq SHALL be registered and equal to the OR of (EDGECAP & IRQMASK), delayed by one cycle.
REQ-024 Bits of in_port that are held constant SHALL never set EDGECAP.

Reset
REQ-025 While reset=1, s1, s2, s3, IRQMASK, EDGECAP, readdata and irq SHALL be 0, immediately and asynchronously.
REQ-026 Reset asserted mid-operation SHALL discard any pending edge or transaction.
REQ-027 After reset deasserts, an in_port bit already high at deassertion SHALL register as one rising edge (s3 leaves reset at 0).

Configuration
REQ-028 With macro SISTEMA_PIO_IN_IRQ_EN defined, IRQMASK and irq SHALL behave as REQ-013 and REQ-023.
REQ-029 Without SISTEMA_PIO_IN_IRQ_EN:
- IRQMASK SHALL not exist, and address 2 SHALL read 0 and ignore writes;
- irq SHALL be tied to 0;
- EDGECAP behaviour SHALL be unchanged.

Verification (WIDTH=14)
REQ-030 Reset test: hold in_port=0, apply reset pulse, read addresses 0..3 -> readdata=0x00000000 each, one cycle after each read; irq=0.
REQ-031 Data sampling test: drive in_port=0x2A5C, wait 2 cycles, read address 0 -> readdata=0x00002A5C; drive in_port=0x3FFF and read immediately -> old value returned.
REQ-032 Edge and clear test: pulse in_port[3] 0->1->0, read address 3 -> 0x00000008; write 0x00000008 to address 3, then read -> 0x00000000.
REQ-033 Clear collision test: arrange an in_port[5] rising edge to reach EDGECAP in the same cycle as a write of 0x20 to address 3 -> read address 3 returns 0x00000020.
REQ-034 Interrupt test: write IRQMASK=0x0001, then raise in_port[1] -> irq stays 0; raise in_port[0] -> irq=1 four cycles after the in_port[0] edge; clear EDGECAP bit 0 -> irq=0 one cycle later.
REQ-035 Macro-off build: write 0xFFFF to address 2, then toggle in_port -> address 2 reads 0 and irq stays 0, while EDGECAP still captures edges.

Source files
------------

// File: rtl/sistema_pio_in.sv
// ============================================================================
// Module  : sistema_pio_in
// Brief   : Memory-mapped parallel input port with synchronizer, rising-edge
//           capture (write-1-to-clear) and optional masked level interrupt.
//           Define SISTEMA_PIO_IN_IRQ_EN to build the IRQMASK register and irq.
// Revision: 1.0 - initial release
// ============================================================================
`default_nettype none

module sistema_pio_in #(
    parameter int WIDTH = 14
) (
    input  logic             clk,
    input  logic             reset,
    input  logic [1:0]       address,
    input  logic             chipselect,
    input  logic             read_n,
    input  logic             write_n,
    input  logic [31:0]      writedata,
    input  logic [WIDTH-1:0] in_port,
    output logic [31:0]      readdata,
    output logic             irq
);

    localparam logic [1:0] c_ADDR_DATA    = 2'd0;
    localparam logic [1:0] c_ADDR_IRQMASK = 2'd2;
    localparam logic [1:0] c_ADDR_EDGECAP = 2'd3;

    logic [WIDTH-1:0] r_s1;
    logic [WIDTH-1:0] r_s2;
    logic [WIDTH-1:0] r_s3;
    logic [WIDTH-1:0] r_edgecap;
    logic [31:0]      r_readdata;

    logic             w_wr;
    logic             w_rd;
    logic [WIDTH-1:0] w_rise;
    logic [WIDTH-1:0] w_clr;
    logic [31:0]      w_rdmux;

    assign w_wr   = chipselect & ~write_n;
    assign w_rd   = chipselect & ~read_n;
    assign w_rise = r_s2 & ~r_s3;
    assign w_clr  = (w_wr && (address == c_ADDR_EDGECAP)) ? writedata[WIDTH-1:0] : '0;

    generate
        if (WIDTH < 32) begin : g_unused_hi
            logic w_unused_wdata_hi;
            assign w_unused_wdata_hi = ^writedata[31:WIDTH];
        end
    endgenerate

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_s1 <= '0;
            r_s2 <= '0;
            r_s3 <= '0;
        end else begin
            r_s1 <= in_port;
            r_s2 <= r_s1;
            r_s3 <= r_s2;
        end
    end

    // A rise landing in the same cycle as a clear keeps the bit set.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_edgecap <= '0;
        end else begin
            r_edgecap <= (r_edgecap & ~w_clr) | w_rise;
        end
    end

`ifdef SISTEMA_PIO_IN_IRQ_EN
    logic [WIDTH-1:0] r_irqmask;
    logic             r_irq;

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_irqmask <= '0;
            r_irq     <= 1'b0;
        end else begin
            if (w_wr && (address == c_ADDR_IRQMASK)) begin
                r_irqmask <= writedata[WIDTH-1:0];
            end
            r_irq <= |(r_edgecap & r_irqmask);
        end
    end

    assign irq = r_irq;
`else
    assign irq = 1'b0;
`endif

    // Read mux sees pre-write register contents, so read+write returns old data.
    always_comb begin
        w_rdmux = '0;
        case (address)
            c_ADDR_DATA:    w_rdmux[WIDTH-1:0] = r_s2;
`ifdef SISTEMA_PIO_IN_IRQ_EN
            c_ADDR_IRQMASK: w_rdmux[WIDTH-1:0] = r_irqmask;
`endif
            c_ADDR_EDGECAP: w_rdmux[WIDTH-1:0] = r_edgecap;
            default:        w_rdmux = '0;
        endcase
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_readdata <= '0;
        end else if (w_rd) begin
            r_readdata <= w_rdmux;
        end
    end

    assign readdata = r_readdata;

endmodule

`default_nettype wire

// File: tb/tb_sistema_pio_in.sv
// ============================================================================
// Module  : tb_sistema_pio_in
// Brief   : Directed plus randomized bench for sistema_pio_in against a
//           sample-history reference model.
// Revision: 1.0 - initial release
// ============================================================================
`default_nettype none

module tb_sistema_pio_in;

    localparam int WIDTH = 14;
`ifdef SISTEMA_PIO_IN_IRQ_EN
    localparam bit c_IRQ = 1'b1;
`else
    localparam bit c_IRQ = 1'b0;
`endif

    logic             clk = 1'b0;
    logic             reset = 1'b0;
    logic [1:0]       address = '0;
    logic             chipselect = 1'b0;
    logic             read_n = 1'b1;
    logic             write_n = 1'b1;
    logic [31:0]      writedata = '0;
    logic [WIDTH-1:0] in_port = '0;
    logic [31:0]      readdata;
    logic             irq;

    int checks = 0;
    int failures = 0;

    // Model: hist[0..2] are in_port samples from the last three edges (newest first).
    logic [WIDTH-1:0] hist [3];
    logic [WIDTH-1:0] m_ecap;
    logic [WIDTH-1:0] m_mask;
    logic [31:0]      m_rd;
    logic             m_irq;

    sistema_pio_in #(.WIDTH(WIDTH)) u_dut (
        .clk        (clk),
        .reset      (reset),
        .address    (address),
        .chipselect (chipselect),
        .read_n     (read_n),
        .write_n    (write_n),
        .writedata  (writedata),
        .in_port    (in_port),
        .readdata   (readdata),
        .irq        (irq)
    );

    always #5 clk = ~clk;

    task automatic check_val(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            failures++;
            $display("FAIL %s got=0x%08h exp=0x%08h", tag, got, exp);
        end
    endtask

    task automatic model_reset();
        for (int i = 0; i < 3; i++) hist[i] = '0;
        m_ecap = '0;
        m_mask = '0;
        m_rd   = '0;
        m_irq  = 1'b0;
    endtask

    // Called just after a negedge: drive, predict, clock, compare.
    task automatic bus_cycle(input logic cs, input logic rdn, input logic wrn,
                             input logic [1:0] a, input logic [31:0] wd,
                             input logic [WIDTH-1:0] inp);
        logic [31:0]      ext;
        logic [WIDTH-1:0] clr;
        logic             nirq;
        chipselect = cs;
        read_n     = rdn;
        write_n    = wrn;
        address    = a;
        writedata  = wd;
        in_port    = inp;
        if (cs && !rdn) begin
            ext = '0;
            case (a)
                2'd0: ext[WIDTH-1:0] = hist[1];
                2'd2: ext[WIDTH-1:0] = c_IRQ ? m_mask : '0;
                2'd3: ext[WIDTH-1:0] = m_ecap;
                default: ext = '0;
            endcase
            m_rd = ext;
        end
        nirq = c_IRQ && ((m_ecap & m_mask) != '0);
        clr  = (cs && !wrn && a == 2'd3) ? wd[WIDTH-1:0] : '0;
        m_ecap = (m_ecap & ~clr) | (hist[1] & ~hist[2]);
        if (c_IRQ && cs && !wrn && a == 2'd2) m_mask = wd[WIDTH-1:0];
        m_irq   = nirq;
        hist[2] = hist[1];
        hist[1] = hist[0];
        hist[0] = inp;
        @(posedge clk);
        #1;
        check_val("readdata", readdata, m_rd);
        check_val("irq", {31'd0, irq}, {31'd0, m_irq});
        @(negedge clk);
    endtask

    task automatic idle(input logic [WIDTH-1:0] inp);
        bus_cycle(1'b0, 1'b1, 1'b1, 2'd0, 32'd0, inp);
    endtask

    task automatic rd(input logic [1:0] a, input logic [WIDTH-1:0] inp);
        bus_cycle(1'b1, 1'b0, 1'b1, a, 32'd0, inp);
    endtask

    task automatic wr(input logic [1:0] a, input logic [31:0] wd, input logic [WIDTH-1:0] inp);
        bus_cycle(1'b1, 1'b1, 1'b0, a, wd, inp);
    endtask

    // Asserted between edges so the asynchronous clear is observable immediately.
    task automatic do_reset(input logic [WIDTH-1:0] inp);
        in_port = inp;
        #2;
        reset = 1'b1;
        #1;
        check_val("async_rst_rd", readdata, 32'd0);
        check_val("async_rst_irq", {31'd0, irq}, 32'd0);
        model_reset();
        repeat (2) @(posedge clk);
        @(negedge clk);
        reset = 1'b0;
    endtask

    initial begin
        logic [WIDTH-1:0] cur;
        model_reset();
        @(negedge clk);

        do_reset('0);
        for (int a = 0; a < 4; a++) begin
            rd(a[1:0], '0);
            check_val("reset_read", readdata, 32'd0);
        end
        check_val("reset_irq", {31'd0, irq}, 32'd0);

        idle(14'h2A5C);
        idle(14'h2A5C);
        rd(2'd0, 14'h2A5C);
        check_val("data_2a5c", readdata, 32'h0000_2A5C);
        rd(2'd0, 14'h3FFF);
        check_val("data_old", readdata, 32'h0000_2A5C);

        repeat (4) idle('0);
        wr(2'd3, 32'h3FFF, '0);
        repeat (3) idle('0);
        idle(14'h0008);
        idle(14'h0000);
        repeat (3) idle('0);
        rd(2'd3, '0);
        check_val("edge_b3", readdata, 32'h0000_0008);
        wr(2'd3, 32'h0000_0008, '0);
        rd(2'd3, '0);
        check_val("edge_clr", readdata, 32'h0000_0000);

        idle(14'h0020);
        idle(14'h0020);
        wr(2'd3, 32'h0000_0020, 14'h0020);
        rd(2'd3, 14'h0020);
        check_val("set_wins", readdata, 32'h0000_0020);
        wr(2'd3, 32'h0000_0020, 14'h0020);

`ifdef SISTEMA_PIO_IN_IRQ_EN
        wr(2'd2, 32'h0000_0001, 14'h0020);
        idle(14'h0022);
        repeat (4) idle(14'h0022);
        check_val("irq_masked", {31'd0, irq}, 32'd0);
        idle(14'h0023);
        idle(14'h0023);
        idle(14'h0023);
        check_val("irq_pre", {31'd0, irq}, 32'd0);
        idle(14'h0023);
        check_val("irq_set", {31'd0, irq}, 32'd1);
        wr(2'd3, 32'h0000_0001, 14'h0023);
        idle(14'h0023);
        check_val("irq_clr", {31'd0, irq}, 32'd0);
`else
        wr(2'd2, 32'h0000_FFFF, 14'h0020);
        idle(14'h0000);
        idle(14'h0001);
        repeat (4) idle(14'h0001);
        rd(2'd2, 14'h0001);
        check_val("mask_absent", readdata, 32'd0);
        check_val("irq_tied", {31'd0, irq}, 32'd0);
        rd(2'd3, 14'h0001);
        check_val("edge_no_irq", readdata, 32'h0000_0001);
`endif

        do_reset(14'h0011);
        repeat (3) idle(14'h0011);
        rd(2'd3, 14'h0011);
        check_val("edge_after_rst", readdata, 32'h0000_0011);

        cur = WIDTH'($urandom);
        for (int n = 0; n < 600; n++) begin
            if ($urandom_range(0, 99) == 0) begin
                do_reset(cur);
            end else begin
                if ($urandom_range(0, 3) == 0) cur = cur ^ WIDTH'($urandom);
                bus_cycle(1'($urandom), 1'($urandom), 1'($urandom),
                          2'($urandom), $urandom, cur);
            end
        end

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule

`default_nettype wire
